// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch: BOOT -> REQ (req/ack to imem) -> HOLD (until decode consumes).
// Consume-to-next-request latency 1 cycle; a fetch is never aborted, fetch_timeout only flags a long wait.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [3:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [31:0] p4;
  logic [31:0] next_pc;

  // Jump keeps the upper nibble of pc+4; branch offset is the immediate in words.
  always_comb begin
    p4 = pc_q + 32'd4;
    if (jump) begin
      next_pc = {p4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      next_pc = p4 + (imm_ext << 2);
    end else begin
      next_pc = p4;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    wait_d        = wait_q;
    timeout_d     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          wait_d        = 4'd0;
          state_d       = HOLD;
        end else if (wait_q != WAIT_MAX) begin
          // Pulse lands on the cycle the count reaches its ceiling; an ack that cycle suppresses it.
          wait_d    = wait_q + 4'd1;
          timeout_d = (wait_q == WAIT_LAST);
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d          = {next_pc[31:2], 2'b00};
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      wait_q        <= 4'd0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      wait_q        <= wait_d;
      timeout_q     <= timeout_d;
    end
  end

  assign imem_req      = (state_q == REQ);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign pc            = pc_q;
  assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXW   = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        branch_taken;
  logic [31:0] imm_ext;
  logic        jump;
  logic [25:0] jump_target;
  logic        fetch_timeout;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .jump         (jump),
    .jump_target  (jump_target),
    .fetch_timeout(fetch_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 = just out of reset, 1 = waiting for imem, 2 = instruction held for decode.
  int          m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  int          m_waits;
  bit          m_to;

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input bit br,
                                           input logic [31:0] imm, input bit jmp,
                                           input logic [25:0] jt);
    longint p4, r;
    p4 = (longint'(cur) + 4) & 64'hFFFF_FFFF;
    if (jmp)     r = ((p4 >> 28) << 28) + longint'(jt) * 4;
    else if (br) r = (p4 + longint'($signed(imm)) * 4) & 64'hFFFF_FFFF;
    else         r = p4;
    return r[31:0];
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_pc = RST_PC; m_instr = 32'd0; m_valid = 1'b0; m_waits = 0; m_to = 1'b0;
  endfunction

  function automatic void model_adv(input bit ack, input logic [31:0] rd, input bit rdy,
                                    input bit br, input logic [31:0] imm, input bit jmp,
                                    input logic [25:0] jt);
    m_to = 1'b0;
    case (m_ph)
      0: m_ph = 1;
      1: begin
        if (ack) begin
          m_instr = rd; m_valid = 1'b1; m_waits = 0; m_ph = 2;
        end else begin
          m_waits++;
          m_to = (m_waits == MAXW);
        end
      end
      2: begin
        if (rdy) begin
          m_pc = ref_next(m_pc, br, imm, jmp, jt); m_valid = 1'b0; m_ph = 1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic check_all();
    check_val("req", 32'(imem_req), 32'(m_ph == 1));
    if (m_ph == 1) check_val("addr", imem_addr, m_pc);
    check_val("valid", 32'(instr_valid), 32'(m_valid));
    check_val("pc", pc, m_pc);
    check_val("timeout", 32'(fetch_timeout), 32'(m_to));
    if (m_valid || m_ph == 0) check_val("instr", instr, m_instr);
  endtask

  // Called just after a falling edge; drives one cycle of inputs and checks at the next falling edge.
  task automatic step(input bit rst, input bit ack, input logic [31:0] rd, input bit rdy,
                      input bit br, input logic [31:0] imm, input bit jmp, input logic [25:0] jt);
    rst_n = !rst;
    imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
    branch_taken = br; imm_ext = imm; jump = jmp; jump_target = jt;
    if (rst) begin
      #1;
      model_reset();
      check_all();
    end else begin
      model_adv(ack, rd, rdy, br, imm, jmp, jt);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input bit ack, input logic [31:0] rd, input bit rdy);
    step(1'b0, ack, rd, rdy, 1'($urandom), $urandom, 1'($urandom), 26'($urandom));
  endtask

  task automatic fetch(input int waits, input logic [31:0] rd);
    repeat (waits) idle_step(1'b0, $urandom, 1'($urandom));
    idle_step(1'b1, rd, 1'($urandom));
  endtask

  task automatic consume(input bit br, input logic [31:0] imm, input bit jmp, input logic [25:0] jt);
    step(1'b0, 1'($urandom), $urandom, 1'b1, br, imm, jmp, jt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int at;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
    branch_taken = 1'b0; imm_ext = 32'd0; jump = 1'b0; jump_target = 26'd0;
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    check_val("rst_instr", instr, 32'd0);
    check_val("rst_pc", pc, RST_PC);

    // Release; ack during BOOT must be dropped.
    step(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);

    for (int i = 0; i < 4; i++) begin
      check_val("seq_req", 32'(imem_req), 32'd1);
      check_val("seq_addr", imem_addr, 32'(i * 4));
      step(1'b0, 1'b1, 32'h2001_0005, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
      check_val("seq_valid", 32'(instr_valid), 32'd1);
      check_val("seq_instr", instr, 32'h2001_0005);
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    end

    fetch(0, $urandom);
    consume(1'b0, 32'd0, 1'b1, 26'h40);
    check_val("jmp_to_100", imem_addr, 32'h0000_0100);

    fetch(1, $urandom);
    consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
    check_val("branch_back", imem_addr, 32'h0000_00FC);

    fetch(0, $urandom);
    consume(1'b1, (32'h1000_0040 - 32'h0000_0100) >> 2, 1'b0, 26'd0);
    check_val("branch_far", imem_addr, 32'h1000_0040);

    fetch(2, $urandom);
    consume(1'b1, $urandom, 1'b1, 26'h000_0010);
    check_val("jump_prio", imem_addr, 32'h1000_0040);

    fetch(0, $urandom);
    consume(1'b1, (32'hFFFF_FFFC - 32'h1000_0044) >> 2, 1'b0, 26'd0);
    check_val("to_top", imem_addr, 32'hFFFF_FFFC);

    fetch(0, $urandom);
    consume(1'b0, $urandom, 1'b0, 26'($urandom));
    check_val("wrap", imem_addr, 32'h0000_0000);

    // Ack withheld for 20 cycles: exactly one timeout pulse, request held throughout.
    cnt = 0; at = 0;
    for (int k = 1; k <= 20; k++) begin
      idle_step(1'b0, $urandom, 1'($urandom));
      check_val("to_req_held", 32'(imem_req), 32'd1);
      if (fetch_timeout) begin cnt++; at = k; end
    end
    check_val("to_count", 32'(cnt), 32'd1);
    check_val("to_when", 32'(at), 32'd15);
    idle_step(1'b1, 32'hA5A5_0001, 1'b0);
    check_val("late_ack_valid", 32'(instr_valid), 32'd1);

    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, $urandom, 1'b0, 1'($urandom), $urandom, 1'($urandom), 26'($urandom));
      check_val("stall_instr", instr, 32'hA5A5_0001);
      check_val("stall_noreq", 32'(imem_req), 32'd0);
    end
    consume(1'b0, 32'd0, 1'b0, 26'd0);

    // Ack on the cycle the count would reach its ceiling: no pulse.
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      idle_step(1'b0, $urandom, 1'b0);
      if (fetch_timeout) cnt++;
    end
    idle_step(1'b1, 32'h0BAD_F00D, 1'b0);
    if (fetch_timeout) cnt++;
    check_val("collide_no_pulse", 32'(cnt), 32'd0);
    consume(1'b0, 32'd0, 1'b0, 26'd0);

    // Reset mid-fetch, then an ack arriving in BOOT.
    idle_step(1'b0, $urandom, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    check_val("rst_req_valid", 32'(instr_valid), 32'd0);
    check_val("rst_req_pc", pc, RST_PC);
    check_val("rst_req_addr", imem_addr, RST_PC);
    check_val("rst_req_req", 32'(imem_req), 32'd1);

    // Reset while holding an instruction.
    fetch(1, 32'h7777_0001);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    check_val("rst_hold_valid", 32'(instr_valid), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, $urandom,
           1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3) == 0, 26'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
